// File: rtl/square_unit_pkg.sv
// Shared definitions for the iterative squarer: state encoding, width
// defaults and the odd-number sequence constants.
package square_unit_pkg;

  localparam int unsigned ROOT_WIDTH_DEF = 8;
  localparam int unsigned SQ_WIDTH_DEF   = 2 * ROOT_WIDTH_DEF;

  // Odd-number identity: n^2 = 1 + 3 + ... + (2n-1)
  localparam int unsigned ODD_INIT = 1;
  localparam int unsigned ODD_STEP = 2;

  // 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/en_reg.sv
// Generic register with synchronous active-low reset and load enable.
module en_reg #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load d when enabled
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/square_datapath.sv
// Datapath for the squarer: count-down counter, odd-number generator and
// accumulator, plus the terminal-count flags used by the controller.
module square_datapath
  import square_unit_pkg::*;
#(
  parameter int unsigned ROOT_WIDTH = ROOT_WIDTH_DEF,
  parameter int unsigned SQ_WIDTH   = 2 * ROOT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ROOT_WIDTH-1:0] root,
  output logic [SQ_WIDTH-1:0]   acc,
  output logic                  count_is_one,
  output logic                  count_is_zero
);

  localparam int unsigned ODD_WIDTH = ROOT_WIDTH + 1;
  localparam logic [ODD_WIDTH-1:0] ODD_RST = ODD_WIDTH'(ODD_INIT);

  logic [ROOT_WIDTH-1:0] count, count_d;
  logic [ODD_WIDTH-1:0]  odd, odd_d;
  logic [SQ_WIDTH-1:0]   acc_d;
  logic                  en;

  assign en = load | step;

  // Next values: operand load takes priority over an accumulate step
  always_comb begin
    count_d = count - ROOT_WIDTH'(1);
    odd_d   = odd + ODD_WIDTH'(ODD_STEP);
    acc_d   = acc + SQ_WIDTH'(odd);
    if (load) begin
      count_d = root;
      odd_d   = ODD_RST;
      acc_d   = '0;
    end
  end

  en_reg #(.WIDTH(ROOT_WIDTH), .RST_VAL('0)) u_count (
    .clk(clk), .rst_n(rst_n), .en(en), .d(count_d), .q(count)
  );

  en_reg #(.WIDTH(ODD_WIDTH), .RST_VAL(ODD_RST)) u_odd (
    .clk(clk), .rst_n(rst_n), .en(en), .d(odd_d), .q(odd)
  );

  en_reg #(.WIDTH(SQ_WIDTH), .RST_VAL('0)) u_acc (
    .clk(clk), .rst_n(rst_n), .en(en), .d(acc_d), .q(acc)
  );

  assign count_is_one  = (count == ROOT_WIDTH'(1));
  assign count_is_zero = (count == '0);

endmodule

// File: rtl/square_unit.sv
// Iterative squarer: accumulates successive odd numbers to form root^2.
// Controller FSM and registered result live here; arithmetic in the datapath.
module square_unit
  import square_unit_pkg::*;
#(
  parameter int unsigned ROOT_WIDTH = ROOT_WIDTH_DEF,
  parameter int unsigned SQ_WIDTH   = 2 * ROOT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ROOT_WIDTH-1:0] root_i,
  output logic                  ready_o,
  output logic [SQ_WIDTH-1:0]   square_o
);

  state_t              state;
  logic                load;
  logic                step;
  logic [SQ_WIDTH-1:0] acc;
  logic                count_is_one;
  logic                count_is_zero;

  assign load    = (state == IDLE) && start_i;
  assign step    = (state == ACCUM);
  assign ready_o = (state == IDLE);

  square_datapath #(
    .ROOT_WIDTH(ROOT_WIDTH),
    .SQ_WIDTH  (SQ_WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .root         (root_i),
    .acc          (acc),
    .count_is_one (count_is_one),
    .count_is_zero(count_is_zero)
  );

  // Sequence IDLE -> ACCUM (n cycles) -> DONE -> IDLE and publish the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      square_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= (root_i != '0) ? ACCUM : DONE;
        end
        ACCUM: begin
          // count_is_zero cannot occur here; it only guards a stuck counter
          if (count_is_one || count_is_zero) state <= DONE;
        end
        DONE: begin
          square_o <= acc;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_unit.sv
// Directed testbench for square_unit.
module tb_square_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  root_i;
  logic        ready_o;
  logic [15:0] square_o;

  int errors;
  int checks;

  square_unit #(.ROOT_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .root_i  (root_i),
    .ready_o (ready_o),
    .square_o(square_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with ready_o low, bounded
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready_o && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  // One pulsed operation; optionally scramble root_i mid-run
  task automatic run_op(input logic [7:0] n, input logic [15:0] exp_sq,
                        input int exp_lat, input bit scramble, input string tag);
    int lat;
    start_i = 1'b1;
    root_i  = n;
    tick();
    start_i = 1'b0;
    if (scramble) root_i = 8'hFF;
    wait_ready(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_sq"}, square_o, exp_sq);
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    start_i = 1'b1;
    root_i  = 8'd5;

    // Reset with start asserted: nothing may start
    tick();
    tick();
    check("rst_ready", ready_o, 1);
    check("rst_square", square_o, 0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("post_rst_ready", ready_o, 1);
    check("post_rst_square", square_o, 0);

    // Basic cases and boundaries
    run_op(8'd0,   16'd0,     1,   1'b0, "root0");
    run_op(8'd1,   16'd1,     2,   1'b0, "root1");
    run_op(8'd12,  16'd144,   13,  1'b1, "root12_scr");
    run_op(8'd255, 16'hFE01,  256, 1'b0, "root255");

    // Result is held while idle
    held = square_o;
    tick();
    tick();
    check("hold_square", square_o, held);
    check("hold_ready", ready_o, 1);

    // Back-to-back with start held high: 3 then 5
    start_i = 1'b1;
    root_i  = 8'd3;
    tick();
    root_i = 8'd5;
    wait_ready(lat);
    check("b2b_lat3", lat, 4);
    check("b2b_sq9", square_o, 9);
    tick();
    check("b2b_one_idle", ready_o, 0);
    start_i = 1'b0;
    wait_ready(lat);
    check("b2b_lat5", lat, 6);
    check("b2b_sq25", square_o, 25);

    // Start pulses while busy are ignored
    start_i = 1'b1;
    root_i  = 8'd4;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    root_i  = 8'd9;
    tick();
    start_i = 1'b0;
    wait_ready(lat);
    check("busy_ign_lat", lat, 3);
    check("busy_ign_sq", square_o, 16);

    // Reset mid-ACCUM aborts
    start_i = 1'b1;
    root_i  = 8'd200;
    tick();
    start_i = 1'b0;
    repeat (50) tick();
    check("mid_busy", ready_o, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", ready_o, 1);
    check("abort_square", square_o, 0);
    tick();
    check("abort_stays_idle", ready_o, 1);
    run_op(8'd7, 16'd49, 8, 1'b0, "after_abort7");

    // Full sweep against n*n
    for (int unsigned n = 0; n < 256; n++) begin
      logic [15:0] exp_sq;
      int          exp_lat;
      exp_sq  = 16'(n * n);
      exp_lat = (n == 0) ? 1 : int'(n) + 1;
      run_op(8'(n), exp_sq, exp_lat, 1'b0, $sformatf("sweep%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/square_unit.md
Name: square_unit

Overview:
- Iterative squarer, the inverse of the team's square-root unit: takes an 8-bit root and returns its 16-bit square.
- Uses the same odd-number identity as the root unit: n² = 1 + 3 + 5 + … + (2n−1). Each cycle adds one odd number.
- Sits next to the root unit. It is used as a self-check (square_o compared with the original valor) and as a stand-alone arithmetic block.
- Control is an FSM; a datapath sub-module holds the count, odd and accumulator registers.

Parameters:
- ROOT_WIDTH, 8: width of root_i.
- SQ_WIDTH, 2*ROOT_WIDTH: width of square_o and the accumulator. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start_i  input  1  request pulse or level; sampled only in IDLE.
- root_i  input  ROOT_WIDTH  operand; captured on the accepted start edge.
- ready_o  output  1  high while in IDLE; unit is free and square_o is valid.
- square_o  output  SQ_WIDTH  registered result; held until the next completion.

Behaviour:
- Reset: one clock and one synchronous active-low reset. On a clk edge with rst_n=0:
  - state=IDLE, count=0, odd=1, acc=0.
  - square_o=0, ready_o=1.
  - Reset mid-operation aborts the computation; no partial result reaches square_o.
- States: IDLE, ACCUM, DONE. ready_o = (state==IDLE), decoded combinationally from the state register.
- IDLE, start_i=1:
  - count<=root_i, acc<=0, odd<=1.
  - Next state is ACCUM if root_i!=0, otherwise DONE.
- IDLE, start_i=0: hold all state.
- ACCUM, every cycle:
  - acc<=acc+odd, odd<=odd+2, count<=count−1.
  - If count==1, next state is DONE; otherwise stay in ACCUM.
- DONE:
  - square_o<=acc (acc already holds n², or 0 for n=0).
  - Next state is IDLE.
- Latency, counted from the start edge to the first edge with ready_o=1:
  - root n≥1: ready_o low for n+1 cycles.
  - root 0: ready_o low for 1 cycle.
  - Worst case is n=255: 256 cycles.
- Handshake:
  - start_i is ignored outside IDLE.
  - root_i may change freely after capture.
  - start_i held high gives back-to-back operations. The new operand is captured on the first IDLE cycle, so ready_o is high for exactly one cycle between jobs.
- Arithmetic:
  - odd is ROOT_WIDTH+1 bits; its maximum is 2*255−1=509, plus the final unused +2.
  - acc is SQ_WIDTH bits, unsigned; the maximum 65025 fits, so no overflow path exists.
  - No saturation logic is needed.
- square_o changes only on the DONE→IDLE edge or on reset; it is stable while ready_o=1.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10; 2'b11 is unused and recovers to IDLE.
  - ROOT_WIDTH/SQ_WIDTH defaults.
  - ODD_INIT=1 and ODD_STEP=2.
- One sub-module, square_datapath, holds:
  - the count, odd and acc registers, built from the team's enable/reset generic register;
  - the two adders and the decrementer;
  - the count_is_one and count_is_zero flags.
- The FSM and the square_o output register live in square_unit.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start_i=1 → square_o=0 and ready_o=1 after release; no operation starts during reset.
- root_i=0 pulse → ready_o low exactly 1 cycle, then square_o=0.
- root_i=1 → ready_o low 2 cycles, square_o=1. root_i=12 with root_i toggled to 0xFF mid-run → square_o=144 after 13 cycles.
- root_i=255 → ready_o low 256 cycles, square_o=65025 (0xFE01). Then sweep all 0..255 against a reference model.
- start_i held high with root_i=3 then 5 → results 9 then 25. ready_o high exactly 1 cycle between jobs; start_i is ignored while busy.
- rst_n low during ACCUM of root_i=200 → next cycle IDLE, ready_o=1, square_o=0. A following root_i=7 yields 49.
